ssp_rx_fifo_wm: RTL and testbench

Parametrised receive FIFO for the SSP receive path, generalising the 4-entry receive buffer.
- Each rising edge of the receiver request is synchronised into the PCLK domain and pushes one word.
- The APB-side read strobe pops one word per cycle.
- Adds a programmable-watermark interrupt, a sticky overrun flag, a receive-timeout interrupt, and level/empty/full status for the SSP register block.

---
 rtl/ssp_rx_fifo_wm.sv | 105 ++++++++++
 tb/tb_ssp_rx_fifo_wm.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/ssp_rx_fifo_wm.sv
// SSP receive FIFO: synchronised request pushes, APB read pops, with watermark,
// sticky overrun and receive-timeout interrupts plus level/empty/full status.
module ssp_rx_fifo_wm #(
  parameter int DATA_WIDTH     = 8,
  parameter int ADDR_WIDTH     = 2,
  parameter int TIMEOUT_CYCLES = 32
) (
  input  logic                  i_PCLK,
  input  logic                  i_CLEAR_B,
  input  logic                  i_PSEL,
  input  logic                  i_PWRITE,
  input  logic                  i_REQ,
  input  logic [DATA_WIDTH-1:0] i_RXDATA,
  input  logic [ADDR_WIDTH:0]   i_WM_LEVEL,
  input  logic                  i_ROR_CLR,
  output logic [DATA_WIDTH-1:0] o_PRDATA,
  output logic [ADDR_WIDTH:0]   o_LEVEL,
  output logic                  o_EMPTY,
  output logic                  o_FULL,
  output logic                  o_SSPRXINTR,
  output logic                  o_SSPRORINTR,
  output logic                  o_SSPRTINTR
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [ADDR_WIDTH:0] DEPTH_L = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [CNT_W-1:0]    TO_MAX  = CNT_W'(TIMEOUT_CYCLES);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic                  s1_q, s2_q, s3_q;
  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH:0]   level_q, level_d;
  logic [DATA_WIDTH-1:0] prdata_q, prdata_d;
  logic                  ovr_q, ovr_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  push_req, rd_req, full, empty, do_push, do_pop, drop;

  assign push_req = s2_q & ~s3_q;
  assign rd_req   = i_PSEL & ~i_PWRITE;
  assign full     = (level_q == DEPTH_L);
  assign empty    = (level_q == '0);
  assign do_pop   = rd_req & ~empty;
  // A pop on a full FIFO frees the slot the simultaneous push writes into.
  assign do_push  = push_req & (~full | do_pop);
  assign drop     = push_req & full & ~do_pop;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    prdata_d = prdata_q;
    ovr_d    = ovr_q;
    cnt_d    = cnt_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
      prdata_d = mem_q[rd_ptr_q];
    end
    if (do_push && !do_pop)      level_d = level_q + 1'b1;
    else if (do_pop && !do_push) level_d = level_q - 1'b1;
    if (drop)           ovr_d = 1'b1;
    else if (i_ROR_CLR) ovr_d = 1'b0;
    if (push_req || do_pop || empty) cnt_d = '0;
    else if (cnt_q != TO_MAX)        cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge i_PCLK or negedge i_CLEAR_B) begin
    if (!i_CLEAR_B) begin
      s1_q     <= 1'b0;
      s2_q     <= 1'b0;
      s3_q     <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      prdata_q <= '0;
      ovr_q    <= 1'b0;
      cnt_q    <= '0;
    end else begin
      s1_q     <= i_REQ;
      s2_q     <= s1_q;
      s3_q     <= s2_q;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      prdata_q <= prdata_d;
      ovr_q    <= ovr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge i_PCLK) begin
    if (do_push) mem_q[wr_ptr_q] <= i_RXDATA;
  end

  assign o_PRDATA     = prdata_q;
  assign o_LEVEL      = level_q;
  assign o_EMPTY      = empty;
  assign o_FULL       = full;
  assign o_SSPRXINTR  = (i_WM_LEVEL != '0) && (level_q >= i_WM_LEVEL);
  assign o_SSPRORINTR = ovr_q;
  assign o_SSPRTINTR  = (cnt_q == TO_MAX);

endmodule

// File: tb/tb_ssp_rx_fifo_wm.sv
// Directed bench for ssp_rx_fifo_wm (DEPTH 4, timeout 32) with hand-computed expectations.
module tb_ssp_rx_fifo_wm;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       psel, pwrite, req, ror_clr;
  logic [7:0] rxdata;
  logic [2:0] wm;
  logic [7:0] prdata;
  logic [2:0] level;
  logic       empty, full, rxintr, rorintr, rtintr;
  int         n_vec = 0;
  int         n_err = 0;

  always #5 clk = ~clk;

  ssp_rx_fifo_wm #(.DATA_WIDTH(8), .ADDR_WIDTH(2), .TIMEOUT_CYCLES(32)) dut (
    .i_PCLK(clk), .i_CLEAR_B(rst_n), .i_PSEL(psel), .i_PWRITE(pwrite),
    .i_REQ(req), .i_RXDATA(rxdata), .i_WM_LEVEL(wm), .i_ROR_CLR(ror_clr),
    .o_PRDATA(prdata), .o_LEVEL(level), .o_EMPTY(empty), .o_FULL(full),
    .o_SSPRXINTR(rxintr), .o_SSPRORINTR(rorintr), .o_SSPRTINTR(rtintr)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Pulse i_REQ for one cycle; the word lands three edges later.
  task automatic push(input logic [7:0] d);
    req = 1'b1; rxdata = d;
    tick();
    req = 1'b0;
    tick();
    tick();
  endtask

  task automatic rd();
    psel = 1'b1; pwrite = 1'b0;
    tick();
    psel = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; psel = 1'b0; pwrite = 1'b0; req = 1'b0; ror_clr = 1'b0;
    rxdata = 8'h00; wm = 3'd0;
    tick(); tick();
    chk("rst_level", 32'(level), 32'd0);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_prdata", 32'(prdata), 32'h00);
    chk("rst_intr", 32'({rxintr, rorintr, rtintr}), 32'd0);
    rst_n = 1'b1;

    // Test 1: single word, latency
    req = 1'b1; rxdata = 8'hA5;
    tick();
    req = 1'b0;
    tick();
    chk("t1_level_e2", 32'(level), 32'd0);
    tick();
    chk("t1_level_e3", 32'(level), 32'd1);
    chk("t1_empty_e3", 32'(empty), 32'd0);
    rd();
    chk("t1_prdata", 32'(prdata), 32'hA5);
    chk("t1_empty", 32'(empty), 32'd1);

    // Test 2: fill, overrun, drain
    push(8'h11); push(8'h22); push(8'h33); push(8'h44);
    chk("t2_full", 32'(full), 32'd1);
    chk("t2_ror_before", 32'(rorintr), 32'd0);
    push(8'h55);
    chk("t2_ror", 32'(rorintr), 32'd1);
    chk("t2_level_full", 32'(level), 32'd4);
    rd(); chk("t2_rd0", 32'(prdata), 32'h11);
    rd(); chk("t2_rd1", 32'(prdata), 32'h22);
    rd(); chk("t2_rd2", 32'(prdata), 32'h33);
    rd(); chk("t2_rd3", 32'(prdata), 32'h44);
    chk("t2_empty", 32'(empty), 32'd1);
    rd(); chk("t2_rd_empty_hold", 32'(prdata), 32'h44);
    chk("t2_ror_held", 32'(rorintr), 32'd1);
    ror_clr = 1'b1;
    tick();
    ror_clr = 1'b0;
    chk("t2_ror_clr", 32'(rorintr), 32'd0);

    // Test 3: watermark
    wm = 3'd3;
    push(8'hA1); chk("t3_wm_l1", 32'(rxintr), 32'd0);
    push(8'hA2); chk("t3_wm_l2", 32'(rxintr), 32'd0);
    push(8'hA3); chk("t3_wm_l3", 32'(rxintr), 32'd1);
    rd();
    chk("t3_wm_pop_data", 32'(prdata), 32'hA1);
    chk("t3_wm_pop", 32'(rxintr), 32'd0);
    wm = 3'd0;
    push(8'hA4);
    chk("t3_wm0_level", 32'(level), 32'd3);
    chk("t3_wm0", 32'(rxintr), 32'd0);
    push(8'hA5);
    wm = 3'd5; #1;
    chk("t3_wm5", 32'(rxintr), 32'd0);
    wm = 3'd4; #1;
    chk("t3_wm4", 32'(rxintr), 32'd1);
    wm = 3'd0;

    // Test 4: push and pop together while full
    req = 1'b1; rxdata = 8'hB6;
    tick();
    req = 1'b0;
    tick();
    psel = 1'b1;
    tick();
    psel = 1'b0;
    chk("t4_prdata", 32'(prdata), 32'hA2);
    chk("t4_level", 32'(level), 32'd4);
    chk("t4_ror", 32'(rorintr), 32'd0);
    rd(); chk("t4_rd1", 32'(prdata), 32'hA3);
    rd(); chk("t4_rd2", 32'(prdata), 32'hA4);
    rd(); chk("t4_rd3", 32'(prdata), 32'hA5);
    rd(); chk("t4_rd4", 32'(prdata), 32'hB6);
    chk("t4_empty", 32'(empty), 32'd1);

    // Test 5: receive timeout
    push(8'hC7);
    repeat (31) tick();
    chk("t5_rt_31", 32'(rtintr), 32'd0);
    tick();
    chk("t5_rt_32", 32'(rtintr), 32'd1);
    rd();
    chk("t5_rd", 32'(prdata), 32'hC7);
    chk("t5_rt_clr", 32'(rtintr), 32'd0);
    repeat (40) tick();
    chk("t5_rt_empty", 32'(rtintr), 32'd0);

    // Test 6: asynchronous reset mid-operation with a request in flight
    push(8'hD1); push(8'hD2);
    chk("t6_level2", 32'(level), 32'd2);
    req = 1'b1; rxdata = 8'hE3;
    tick();
    req = 1'b0;
    tick();
    #2 rst_n = 1'b0;
    #1;
    chk("t6_async_level", 32'(level), 32'd0);
    chk("t6_async_empty", 32'(empty), 32'd1);
    chk("t6_async_prdata", 32'(prdata), 32'h00);
    tick();
    rst_n = 1'b1;
    tick(); tick(); tick();
    chk("t6_inflight_dropped", 32'(level), 32'd0);
    rd();
    chk("t6_rd_prdata", 32'(prdata), 32'h00);
    chk("t6_rd_empty", 32'(empty), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
